multicycle_controller: RTL and testbench

- Control FSM for the multicycle RISC-V RV32I core; successor to the single-cycle main control decode.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB, driving datapath enables and mux selects per state.
- Adds memory ready/valid wait states, full branch set (beq/bne/blt/bge/bltu/bgeu), lui/auipc, and an illegal-opcode trap.
- Sits between the instruction register and the shared instruction/data memory port; ALU function decode stays in the existing ALU decoder, fed by ALUOp.

---
 rtl/multicycle_controller_pkg.sv | 75 +++++++
 rtl/multicycle_controller_if.sv | 44 ++++
 rtl/multicycle_controller_branch_cond.sv | 27 ++
 rtl/multicycle_controller.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Package for the multicycle RV32I control FSM.
// Contents: the FSM state encoding, the base opcode constants, the mux-select
// and ALUOp encodings driven towards the datapath, the funct3 codes used by
// the branch comparator, and a helper that flags reserved branch funct3 values.
package riscv_ctrl_pkg;

  // Controller states. The 4-bit encoding is exposed on the debug port.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_UPPER    = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Base opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU B mux
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // ALUOp towards the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 010 and 011 are reserved in the branch opcode space.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle controller and the datapath / memory port.
// master: controller side (takes IR fields, ALU flags and MemReady; drives
//         enables and mux selects).
// slave : datapath side (the reverse).
//
// Memory handshake: MemReq is the request valid, MemReady the completion.
// A request stays asserted, with address select stable, until the cycle in
// which MemReady=1; that cycle is the only one in which the access takes
// effect (IRWrite/PCWrite in fetch, MemWrite in a store). MemWrite is only
// ever high together with MemReq.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       Lt;
  logic       Ltu;
  logic       MemReady;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemReq;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [1:0] ALUOp;
  logic       InstrDone;
  logic       IllegalInstr;

  modport master (
    input  op, funct3, Zero, Lt, Ltu, MemReady,
    output PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, InstrDone, IllegalInstr
  );

  modport slave (
    output op, funct3, Zero, Lt, Ltu, MemReady,
    input  PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, InstrDone, IllegalInstr
  );
endinterface

// File: rtl/multicycle_controller_branch_cond.sv
// Branch condition evaluator, purely combinational.
// Ports: funct3 (branch kind), Zero/Lt/Ltu (ALU flags from the compare),
//        taken (1 = branch condition holds). Reserved funct3 values give 0.
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = Zero;
      F3_BNE:  taken = !Zero;
      F3_BLT:  taken = Lt;
      F3_BGE:  taken = !Lt;
      F3_BLTU: taken = Ltu;
      F3_BGEU: taken = !Ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM of the multicycle RV32I core.
// Sequences fetch / decode / execute / memory / writeback and drives the
// datapath enables and mux selects for each state. ALU function decode is
// left to the external ALU decoder, fed through ALUOp.
//
// Parameters:
//   MEM_HANDSHAKE 1: memory states wait for MemReady; 0: MemReady ignored.
//   UPPER_EN      1: lui/auipc supported; 0: they decode as illegal.
//   TRAP_EN       1: illegal decode parks in TRAP until reset;
//                 0: illegal decode drops back to FETCH without retiring.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; returns the FSM to FETCH
//   bus        controller side of multicycle_controller_if
//   dbg_state  current FSM state
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit UPPER_EN      = 1'b1,
  parameter bit TRAP_EN       = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus,
  output state_t                  dbg_state
);

  state_t     state;
  state_t     decode_next;
  logic       ready;
  logic       taken;

  logic       pc_write;
  logic       adr_src;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [1:0] alu_op;

  // Without the handshake every memory state completes in one cycle.
  assign ready = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  branch_cond u_branch_cond (
    .funct3 (bus.funct3),
    .Zero   (bus.Zero),
    .Lt     (bus.Lt),
    .Ltu    (bus.Ltu),
    .taken  (taken)
  );

  // Successor of DECODE, selected by the freshly loaded opcode.
  always_comb begin
    decode_next = TRAP_EN ? S_TRAP : S_FETCH;
    case (bus.op)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXECR;
      OP_ITYPE:          decode_next = S_EXECI;
      OP_BRANCH: begin
        if (branch_f3_legal(bus.funct3)) decode_next = S_BRANCH;
      end
      OP_JAL:            decode_next = S_JAL;
      OP_LUI, OP_AUIPC: begin
        if (UPPER_EN) decode_next = S_UPPER;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next;
        S_MEMADR:   state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_BRANCH:   state <= S_FETCH;
        S_UPPER:    state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Per-state control word. Strobes that complete a memory access follow
  // ready so they fire exactly once, in the completing cycle.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = ready;
        pc_write   = ready;
      end
      S_DECODE: begin
        // Branch/jump target is computed here and held in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (bus.op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = bus.op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_req    = 1'b1;
        mem_write  = ready;
        instr_done = ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC <= target from ALUOut while the ALU forms OldPC+4 for rd.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        pc_write   = taken;
        instr_done = 1'b1;
      end
      S_UPPER: begin
        // lui adds to zero, auipc adds to the instruction's own PC.
        alu_src_a = bus.op[5] ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked directly by reset so an access cut short by reset
  // cannot complete, without waiting for a clock edge.
  assign bus.PCWrite      = pc_write   & ~reset;
  assign bus.MemReq       = mem_req    & ~reset;
  assign bus.MemWrite     = mem_write  & ~reset;
  assign bus.IRWrite      = ir_write   & ~reset;
  assign bus.RegWrite     = reg_write  & ~reset;
  assign bus.InstrDone    = instr_done & ~reset;
  assign bus.IllegalInstr = illegal    & ~reset;
  assign bus.AdrSrc       = adr_src;
  assign bus.ResultSrc    = result_src;
  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.ImmSrc       = imm_src;
  assign bus.ALUOp        = alu_op;

  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances, one with all features on
// (handshake, lui/auipc, trap) and one with all off. Only the selected
// instance runs; the other is held in reset.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_a;
  logic reset_b;

  // ---------------- shared stimulus ----------------
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  bit         cfg_b;     // 0: full-feature instance, 1: reduced instance
  bit         fix_ltu;   // hold Ltu=1 for directed branch checks

  multicycle_controller_if if_a ();
  multicycle_controller_if if_b ();

  assign if_a.op = op;        assign if_b.op = op;
  assign if_a.funct3 = funct3; assign if_b.funct3 = funct3;
  assign if_a.Zero = zero;    assign if_b.Zero = zero;
  assign if_a.Lt = lt;        assign if_b.Lt = lt;
  assign if_a.Ltu = ltu;      assign if_b.Ltu = ltu;
  assign if_a.MemReady = mem_ready;
  assign if_b.MemReady = mem_ready;

  state_t state_a;
  state_t state_b;

  multicycle_controller #(
    .MEM_HANDSHAKE (1'b1), .UPPER_EN (1'b1), .TRAP_EN (1'b1)
  ) dut_a (
    .clk (clk), .reset (reset_a), .bus (if_a), .dbg_state (state_a)
  );

  multicycle_controller #(
    .MEM_HANDSHAKE (1'b0), .UPPER_EN (1'b0), .TRAP_EN (1'b0)
  ) dut_b (
    .clk (clk), .reset (reset_b), .bus (if_b), .dbg_state (state_b)
  );

  // Observed control word, MSB first:
  // PCWrite AdrSrc MemReq MemWrite IRWrite RegWrite ResultSrc[2] ALUSrcA[2]
  // ALUSrcB[2] ImmSrc[3] ALUOp[2] InstrDone IllegalInstr
  localparam int B_MREQ = 16;
  localparam int B_MW   = 15;
  localparam int B_DONE = 1;
  localparam int B_ILL  = 0;

  logic [18:0] ctrl_a;
  logic [18:0] ctrl_b;
  logic [18:0] ctrl_obs;
  state_t      state_obs;

  assign ctrl_a = {if_a.PCWrite, if_a.AdrSrc, if_a.MemReq, if_a.MemWrite, if_a.IRWrite,
                   if_a.RegWrite, if_a.ResultSrc, if_a.ALUSrcA, if_a.ALUSrcB, if_a.ImmSrc,
                   if_a.ALUOp, if_a.InstrDone, if_a.IllegalInstr};
  assign ctrl_b = {if_b.PCWrite, if_b.AdrSrc, if_b.MemReq, if_b.MemWrite, if_b.IRWrite,
                   if_b.RegWrite, if_b.ResultSrc, if_b.ALUSrcA, if_b.ALUSrcB, if_b.ImmSrc,
                   if_b.ALUOp, if_b.InstrDone, if_b.IllegalInstr};
  assign ctrl_obs  = cfg_b ? ctrl_b : ctrl_a;
  assign state_obs = cfg_b ? state_b : state_a;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt;
  state_t plan_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected control word for one cycle spent in phase p.
  function automatic logic [18:0] exp_ctrl(input state_t p, input logic [6:0] o,
                                           input logic [2:0] f, input logic z,
                                           input logic l, input logic lu, input logic rdy);
    logic pcw, adr, mreq, mw, irw, rw, done, ill, flag;
    logic [1:0] rs, sa, sb, aop;
    logic [2:0] imm;
    {pcw, adr, mreq, mw, irw, rw, done, ill} = 8'h00;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; aop = 2'd0; imm = 3'd0;
    case (p)
      S_FETCH:    begin mreq = 1; sb = 2; rs = 2; irw = rdy; pcw = rdy; end
      S_DECODE:   begin sa = 1; sb = 1; imm = (o == 7'b1101111) ? 3'd3 : 3'd2; end
      S_MEMADR:   begin sa = 2; sb = 1; imm = o[5] ? 3'd1 : 3'd0; end
      S_MEMREAD:  begin adr = 1; mreq = 1; end
      S_MEMWB:    begin rs = 1; rw = 1; done = 1; end
      S_MEMWRITE: begin adr = 1; mreq = 1; mw = rdy; done = rdy; end
      S_EXECR:    begin sa = 2; aop = 2; end
      S_EXECI:    begin sa = 2; sb = 1; aop = 2; end
      S_ALUWB:    begin rw = 1; done = 1; end
      S_JAL:      begin sa = 1; sb = 2; pcw = 1; end
      S_BRANCH: begin
        // f[2:1] picks the flag (00 Zero, 10 Lt, 11 Ltu), f[0] inverts it.
        flag = (f[2:1] == 2'b00) ? z : (f[2:1] == 2'b10) ? l : lu;
        sa = 2; aop = 1; pcw = flag ^ f[0]; done = 1;
      end
      S_UPPER:    begin sa = o[5] ? 2'd3 : 2'd1; sb = 1; imm = 3'd4; end
      S_TRAP:     ill = 1;
      default: ;
    endcase
    return {pcw, adr, mreq, mw, irw, rw, rs, sa, sb, imm, aop, done, ill};
  endfunction

  // Phases an instruction walks through in the selected configuration.
  task automatic build_plan(input logic [6:0] o, input logic [2:0] f);
    bit bad;
    bad = 0;
    plan_q = {};
    plan_q.push_back(S_FETCH);
    plan_q.push_back(S_DECODE);
    case (o)
      7'b0000011: begin plan_q.push_back(S_MEMADR); plan_q.push_back(S_MEMREAD);
                        plan_q.push_back(S_MEMWB); end
      7'b0100011: begin plan_q.push_back(S_MEMADR); plan_q.push_back(S_MEMWRITE); end
      7'b0110011: begin plan_q.push_back(S_EXECR); plan_q.push_back(S_ALUWB); end
      7'b0010011: begin plan_q.push_back(S_EXECI); plan_q.push_back(S_ALUWB); end
      7'b1100011: if (f == 3'b010 || f == 3'b011) bad = 1; else plan_q.push_back(S_BRANCH);
      7'b1101111: begin plan_q.push_back(S_JAL); plan_q.push_back(S_ALUWB); end
      7'b0110111, 7'b0010111:
        if (cfg_b) bad = 1;
        else begin plan_q.push_back(S_UPPER); plan_q.push_back(S_ALUWB); end
      default: bad = 1;
    endcase
    if (bad && !cfg_b) plan_q.push_back(S_TRAP);
  endtask

  // ---------------- driver ----------------
  task automatic set_reset(input logic v);
    if (cfg_b) reset_b = v; else reset_a = v;
  endtask

  task automatic use_cfg(input bit c);
    reset_a = 1'b1;
    reset_b = 1'b1;
    cfg_b = c;
    @(posedge clk); #1;
    set_reset(1'b0);
  endtask

  // One clock cycle in phase p; entered and left at posedge+1.
  task automatic step(input state_t p, input bit rdy, input string name);
    logic [18:0] e;
    mem_ready = cfg_b ? 1'($urandom_range(0, 1)) : rdy;
    zero = 1'($urandom_range(0, 1));
    lt   = 1'($urandom_range(0, 1));
    ltu  = fix_ltu ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    e = exp_ctrl(p, op, funct3, zero, lt, ltu, cfg_b ? 1'b1 : rdy);
    check({name, ":state"}, state_obs, p);
    check({name, ":ctrl"}, ctrl_obs, e);
    if (ctrl_obs[B_DONE]) done_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input int waits,
                           input string name);
    bit retired;
    state_t p;
    int nw;
    retired = 0;
    done_cnt = 0;
    op = o;
    funct3 = f;
    build_plan(o, f);
    foreach (plan_q[i]) begin
      p = plan_q[i];
      if (p == S_TRAP) begin
        for (int c = 0; c < 10; c++) step(p, 1'b1, name);
        set_reset(1'b1);
        #1;
        check({name, ":trap_clear"}, ctrl_obs[B_ILL], 1'b0);
        check({name, ":trap_exit"}, state_obs, S_FETCH);
        #1;
        set_reset(1'b0);
      end else begin
        nw = (!cfg_b && (p == S_FETCH || p == S_MEMREAD || p == S_MEMWRITE)) ? waits : 0;
        for (int w = 0; w <= nw; w++) step(p, w == nw, name);
      end
      if (p == S_MEMWB || p == S_MEMWRITE || p == S_ALUWB || p == S_BRANCH) retired = 1;
    end
    check({name, ":done_count"}, done_cnt, {31'd0, retired});
  endtask

  // Store parked in MEMWRITE, then reset with no clock edge in between.
  task automatic reset_in_store();
    op = 7'b0100011;
    funct3 = 3'b010;
    step(S_FETCH, 1'b1, "rst_sw");
    step(S_DECODE, 1'b1, "rst_sw");
    step(S_MEMADR, 1'b1, "rst_sw");
    mem_ready = 1'b0;
    @(negedge clk);
    check("rst_sw:req_wait", ctrl_obs[B_MREQ], 1'b1);
    #2 reset_a = 1'b1;
    #1;
    check("rst_sw:req_off", ctrl_obs[B_MREQ], 1'b0);
    check("rst_sw:write_off", ctrl_obs[B_MW], 1'b0);
    check("rst_sw:state", state_obs, S_FETCH);
    mem_ready = 1'b1;
    #1;
    check("rst_sw:no_late_write", ctrl_obs[B_MW], 1'b0);
    @(posedge clk); #1;
    reset_a = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [6:0] op_tbl [10];

  initial begin
    op_tbl = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
               7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0001111};
    reset_a = 1'b1; reset_b = 1'b1; cfg_b = 0; fix_ltu = 0;
    op = '0; funct3 = '0; zero = 0; lt = 0; ltu = 0; mem_ready = 0;

    @(negedge clk);
    check("reset:ctrl", ctrl_a, {6'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 2'b00});
    check("reset:state", state_a, S_FETCH);
    @(posedge clk); #1;
    reset_a = 1'b0;

    run_instr(7'b0000011, 3'b010, 2, "lw_wait");
    fix_ltu = 1;
    run_instr(7'b1100011, 3'b110, 0, "bltu");
    run_instr(7'b1100011, 3'b111, 0, "bgeu");
    fix_ltu = 0;
    run_instr(7'b0110111, 3'b000, 0, "lui");
    run_instr(7'b0010111, 3'b000, 0, "auipc");
    run_instr(7'b1101111, 3'b000, 1, "jal");
    run_instr(7'b1111111, 3'b000, 0, "trap");
    run_instr(7'b1100011, 3'b011, 0, "br_bad_f3");
    reset_in_store();
    run_instr(7'b0110011, 3'b000, 1, "after_rst");

    for (int i = 0; i < 40; i++)
      run_instr(op_tbl[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), "rand_a");

    use_cfg(1'b1);
    run_instr(7'b0100011, 3'b010, 0, "sw_nohs");
    run_instr(7'b0110111, 3'b000, 0, "lui_off");
    run_instr(7'b1111111, 3'b000, 0, "bad_notrap");
    run_instr(7'b0000011, 3'b010, 0, "lw_nohs");
    for (int i = 0; i < 25; i++)
      run_instr(op_tbl[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), 0, "rand_b");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
